// File: rtl/pipe_pkg.sv
// Shared types and constants for the RV32I pipeline control blocks.
package pipe_pkg;

    localparam int          REG_ADDR_W = 5;
    localparam logic [31:0] NOP_INSTR  = 32'h00000013;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clear,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_count;

    // Count register; holds at all-ones once saturated.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + ONE;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory freeze, redirect
// bubbles and load-use stalls, plus stall counter and sticky memory timeout.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REDIRECT_BUBBLES = 1,
    parameter int MEM_TIMEOUT      = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [REG_ADDR_W-1:0] rs1_ID,
    input  logic [REG_ADDR_W-1:0] rs2_ID,
    input  logic                  use_rs1_ID,
    input  logic                  use_rs2_ID,
    input  logic [REG_ADDR_W-1:0] rd_EX,
    input  logic                  mem_read_EX,
    input  logic                  redirect_EX,
    input  logic                  dmem_req_MEM,
    input  logic                  dmem_ready,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  if_id_flush,
    output logic                  id_ex_en,
    output logic                  id_ex_flush,
    output logic                  ex_mem_en,
    output logic                  mem_wb_flush,
    output logic [31:0]           stall_count,
    output logic                  mem_timeout
);

    localparam logic [2:0]  BUBBLES    = 3'(REDIRECT_BUBBLES);
    localparam logic [15:0] TIMEOUT_M1 = 16'(MEM_TIMEOUT - 1);

    ctrl_state_t r_state;
    ctrl_state_t w_next_state;
    logic [2:0]  r_bubble;
    logic [2:0]  w_next_bubble;
    logic        r_mem_timeout;
    logic        w_freeze;
    logic        w_load_use;
    logic [15:0] w_wait_cnt;

    assign w_freeze   = dmem_req_MEM && !dmem_ready;
    assign w_load_use = mem_read_EX && (rd_EX != 5'd0) &&
                        ((use_rs1_ID && (rs1_ID == rd_EX)) ||
                         (use_rs2_ID && (rs2_ID == rd_EX)));

    // Next-state and pipeline control, in priority order.
    always_comb begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_flush  = 1'b0;
        w_next_state  = r_state;
        w_next_bubble = r_bubble;
        if (i_rst) begin
            w_next_state  = RUN;
            w_next_bubble = 3'd0;
        end else if (w_freeze) begin
            // Bubble count is held so the redirect shadow resumes after the wait.
            mem_wb_flush = 1'b1;
            w_next_state = MEM_WAIT;
        end else begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            if (redirect_EX) begin
                if_id_flush   = 1'b1;
                id_ex_flush   = 1'b1;
                w_next_bubble = BUBBLES;
                w_next_state  = (BUBBLES != 3'd0) ? REDIRECT : RUN;
            end else if (r_state == REDIRECT) begin
                if_id_flush   = 1'b1;
                w_next_bubble = (r_bubble != 3'd0) ? (r_bubble - 3'd1) : 3'd0;
                w_next_state  = (r_bubble <= 3'd1) ? RUN : REDIRECT;
            end else begin
                if (w_load_use) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end else begin
                    id_ex_flush = 1'b0;
                end
                w_next_state = (r_bubble != 3'd0) ? REDIRECT : RUN;
            end
        end
    end

    // State and bubble counter registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= RUN;
            r_bubble <= 3'd0;
        end else begin
            r_state  <= w_next_state;
            r_bubble <= w_next_bubble;
        end
    end

    // Sticky timeout; sets on the edge that completes MEM_TIMEOUT frozen cycles.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mem_timeout <= 1'b0;
        end else if (w_freeze && (w_wait_cnt >= TIMEOUT_M1)) begin
            r_mem_timeout <= 1'b1;
        end else begin
            r_mem_timeout <= r_mem_timeout;
        end
    end

    sat_counter #(.W(16)) u_wait_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (!w_freeze),
        .i_inc   (w_freeze),
        .o_count (w_wait_cnt)
    );

    sat_counter #(.W(32)) u_stall_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (1'b0),
        .i_inc   (!pc_en),
        .o_count (stall_count)
    );

    assign mem_timeout = r_mem_timeout;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Table-driven scoreboard bench for hazard_ctrl (REDIRECT_BUBBLES=2, MEM_TIMEOUT=3).
module tb_hazard_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [4:0]  rs1_ID, rs2_ID, rd_EX;
    logic        use_rs1_ID, use_rs2_ID, mem_read_EX, redirect_EX;
    logic        dmem_req_MEM, dmem_ready;
    logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush;
    logic [31:0] stall_count;
    logic        mem_timeout;

    hazard_ctrl #(.REDIRECT_BUBBLES(2), .MEM_TIMEOUT(3)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .rs1_ID       (rs1_ID),
        .rs2_ID       (rs2_ID),
        .use_rs1_ID   (use_rs1_ID),
        .use_rs2_ID   (use_rs2_ID),
        .rd_EX        (rd_EX),
        .mem_read_EX  (mem_read_EX),
        .redirect_EX  (redirect_EX),
        .dmem_req_MEM (dmem_req_MEM),
        .dmem_ready   (dmem_ready),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .if_id_flush  (if_id_flush),
        .id_ex_en     (id_ex_en),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_en    (ex_mem_en),
        .mem_wb_flush (mem_wb_flush),
        .stall_count  (stall_count),
        .mem_timeout  (mem_timeout)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [4:0] rs1; logic [4:0] rs2; logic u1; logic u2;
        logic [4:0] rd;  logic mr; logic redir; logic req; logic rdy;
    } stim_t;

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush}
    typedef logic [6:0] ctl_t;

    typedef struct packed { ctl_t c; logic to; logic [31:0] sc; } exp_t;
    typedef struct packed { stim_t s; ctl_t c; logic to; } vec_t;

    localparam ctl_t C_NORM = 7'b1101010;
    localparam ctl_t C_LU   = 7'b0001110;
    localparam ctl_t C_RDR  = 7'b1111110;
    localparam ctl_t C_BUB  = 7'b1111010;
    localparam ctl_t C_FRZ  = 7'b0000001;
    localparam ctl_t C_OFF  = 7'b0000000;

    exp_t        sb_q[$];
    vec_t        tbl[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_stall = 32'd0;

    function automatic stim_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic [4:0] rd,
                                 input logic mr, input logic redir, input logic req,
                                 input logic rdy);
        stim_t s;
        s = '{rs1: rs1, rs2: rs2, u1: u1, u2: u2, rd: rd, mr: mr,
              redir: redir, req: req, rdy: rdy};
        return s;
    endfunction

    function automatic ctl_t ctl_now();
        return {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush};
    endfunction

    task automatic drive(input stim_t s);
        rs1_ID = s.rs1; rs2_ID = s.rs2; use_rs1_ID = s.u1; use_rs2_ID = s.u2;
        rd_EX = s.rd; mem_read_EX = s.mr; redirect_EX = s.redir;
        dmem_req_MEM = s.req; dmem_ready = s.rdy;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle, push its expectation, compare on the falling edge.
    task automatic step(input stim_t s, input ctl_t c, input logic to, input string name);
        exp_t e;
        drive(s);
        e.c = c; e.to = to; e.sc = exp_stall;
        sb_q.push_back(e);
        @(negedge i_clk);
        e = sb_q.pop_front();
        check({name, " ctl"},   32'(ctl_now()),  32'(e.c));
        check({name, " stall"}, stall_count,     e.sc);
        check({name, " tmo"},   32'(mem_timeout), 32'(e.to));
        if (!e.c[6] && !i_rst) exp_stall = exp_stall + 32'd1;
        @(posedge i_clk);
        #1;
    endtask

    task automatic add(input stim_t s, input ctl_t c, input logic to);
        vec_t v;
        v.s = s; v.c = c; v.to = to;
        tbl.push_back(v);
    endtask

    initial begin
        stim_t idle, lu1, lu2, lu_rd0, lu_nouse, lu_noload, redir, frz, frz_rdr, rdy, rdy_rdr;
        idle      = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        lu1       = mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        lu2       = mk(5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        lu_rd0    = mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        lu_nouse  = mk(5'd5, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        lu_noload = mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        redir     = mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        frz       = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        frz_rdr   = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        rdy       = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        rdy_rdr   = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);

        add(idle, C_NORM, 1'b0);
        add(lu1, C_LU, 1'b0);
        add(idle, C_NORM, 1'b0);
        add(lu2, C_LU, 1'b0);
        add(lu_rd0, C_NORM, 1'b0);
        add(lu_nouse, C_NORM, 1'b0);
        add(lu_noload, C_NORM, 1'b0);
        add(redir, C_RDR, 1'b0);
        add(idle, C_BUB, 1'b0);
        add(lu1, C_BUB, 1'b0);
        add(idle, C_NORM, 1'b0);
        add(frz, C_FRZ, 1'b0);
        add(frz, C_FRZ, 1'b0);
        add(frz, C_FRZ, 1'b0);
        add(frz, C_FRZ, 1'b1);
        add(rdy, C_NORM, 1'b1);
        add(frz_rdr, C_FRZ, 1'b1);
        add(frz_rdr, C_FRZ, 1'b1);
        add(frz_rdr, C_FRZ, 1'b1);
        add(rdy_rdr, C_RDR, 1'b1);
        add(idle, C_BUB, 1'b1);
        add(idle, C_BUB, 1'b1);
        add(idle, C_NORM, 1'b1);
        add(redir, C_RDR, 1'b1);
        add(idle, C_BUB, 1'b1);
        add(frz, C_FRZ, 1'b1);
        add(rdy, C_NORM, 1'b1);
        add(idle, C_BUB, 1'b1);
        add(idle, C_NORM, 1'b1);

        i_rst = 1'b1;
        step(idle, C_OFF, 1'b0, "reset");
        i_rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].s, tbl[i].c, tbl[i].to, $sformatf("vec%0d", i));
        end

        // Synchronous-style reset clears the sticky flag and stall counter.
        i_rst = 1'b1;
        exp_stall = 32'd0;
        step(idle, C_OFF, 1'b0, "reset2");
        i_rst = 1'b0;

        step(frz, C_FRZ, 1'b0, "tmo_c1");
        step(frz, C_FRZ, 1'b0, "tmo_c2");
        step(frz, C_FRZ, 1'b0, "tmo_c3");
        step(frz, C_FRZ, 1'b1, "tmo_c4");
        step(frz, C_FRZ, 1'b1, "tmo_c5");

        // Reset asserted between clock edges must take effect without an edge.
        check("pre_async stall", stall_count, 32'd5);
        #2;
        i_rst = 1'b1;
        #1;
        check("async ctl",   32'(ctl_now()),   32'(C_OFF));
        check("async stall", stall_count,      32'd0);
        check("async tmo",   32'(mem_timeout), 32'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        exp_stall = 32'd0;
        step(idle, C_NORM, 1'b0, "post_async");
        step(lu1, C_LU, 1'b0, "post_async_lu");
        step(idle, C_NORM, 1'b0, "post_async_norm");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
